// File: rtl/pc_gen.sv
// Fetch-stage PC generator: owns pcF and drives the instruction-SRAM req/addr_ok
// handshake, with a one-entry pending slot so redirects survive stalls.
module pc_gen #(
    parameter int unsigned     PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'hbfc0_0000),
    parameter logic [PC_W-1:0] EXC_PC   = PC_W'(32'hbfc0_0380)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            stallF,
    input  logic            exc_valid,
    input  logic            eret_valid,
    input  logic [PC_W-1:0] eret_pc,
    input  logic            jumpD,
    input  logic [PC_W-1:0] pc_jumpD,
    input  logic            branch_takeD,
    input  logic [PC_W-1:0] pc_branchD,
    input  logic            inst_addr_ok,
    output logic            inst_req,
    output logic [PC_W-1:0] inst_addr,
    output logic [PC_W-1:0] pcF,
    output logic [PC_W-1:0] pc_plus4F,
    output logic            adelF
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_REQ   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    // Encoding order doubles as redirect priority for the slot overwrite rule.
    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_BRANCH = 2'd1,
        CLS_JUMP   = 2'd2,
        CLS_ERET   = 2'd3
    } cls_t;

    state_t            state_reg, state_next;
    logic [PC_W-1:0]   pc_reg, pc_next;
    logic              slot_valid_reg, slot_valid_next;
    logic [PC_W-1:0]   slot_pc_reg, slot_pc_next;
    cls_t              slot_cls_reg, slot_cls_next;

    logic              live_valid;
    cls_t              live_cls;
    logic [PC_W-1:0]   live_pc;
    logic              fire;

    assign pcF       = pc_reg;
    assign inst_addr = pc_reg;
    assign pc_plus4F = pc_reg + PC_W'(4);
    assign adelF     = |pc_reg[1:0];
    assign inst_req  = (state_reg == ST_REQ) && !adelF;
    assign fire      = inst_req && inst_addr_ok;

    always_comb begin
        live_valid = 1'b1;
        live_cls   = CLS_NONE;
        live_pc    = pc_branchD;
        if (eret_valid) begin
            live_cls = CLS_ERET;
            live_pc  = eret_pc;
        end else if (jumpD) begin
            live_cls = CLS_JUMP;
            live_pc  = pc_jumpD;
        end else if (branch_takeD) begin
            live_cls = CLS_BRANCH;
            live_pc  = pc_branchD;
        end else begin
            live_valid = 1'b0;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        slot_valid_next = slot_valid_reg;
        slot_pc_next    = slot_pc_reg;
        slot_cls_next   = slot_cls_reg;

        case (state_reg)
            ST_BOOT:  state_next = ST_REQ;
            ST_REQ: begin
                if (fire) begin
                    state_next = stallF ? ST_STALL : ST_REQ;
                end
            end
            ST_STALL: begin
                if (!stallF) begin
                    state_next = ST_REQ;
                end
            end
            default:  state_next = ST_BOOT;
        endcase

        if (fire) begin
            if (live_valid) begin
                pc_next = live_pc;
            end else if (slot_valid_reg) begin
                pc_next = slot_pc_reg;
            end else begin
                pc_next = pc_plus4F;
            end
            slot_valid_next = 1'b0;
            slot_cls_next   = CLS_NONE;
        end else if (live_valid && (!slot_valid_reg || live_cls >= slot_cls_reg)) begin
            slot_valid_next = 1'b1;
            slot_pc_next    = live_pc;
            slot_cls_next   = live_cls;
        end

        // An exception flush abandons the in-flight address and any held redirect.
        if (exc_valid && state_reg != ST_BOOT) begin
            state_next      = ST_REQ;
            pc_next         = EXC_PC;
            slot_valid_next = 1'b0;
            slot_cls_next   = CLS_NONE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= ST_BOOT;
            pc_reg         <= RESET_PC;
            slot_valid_reg <= 1'b0;
            slot_pc_reg    <= '0;
            slot_cls_reg   <= CLS_NONE;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            slot_valid_reg <= slot_valid_next;
            slot_pc_reg    <= slot_pc_next;
            slot_cls_reg   <= slot_cls_next;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the fetch PC.
module tb_pc_gen;

    localparam logic [31:0] RESET_PC = 32'hbfc0_0000;
    localparam logic [31:0] EXC_PC   = 32'hbfc0_0380;

    logic        clk = 1'b0;
    logic        resetn;
    logic        stallF, exc_valid, eret_valid, jumpD, branch_takeD, inst_addr_ok;
    logic [31:0] eret_pc, pc_jumpD, pc_branchD;
    logic        inst_req, adelF;
    logic [31:0] inst_addr, pcF, pc_plus4F;

    int checks = 0;
    int passed = 0;

    // Behavioural model: mode 0=boot, 1=requesting, 2=stalled.
    int          m_mode;
    logic [31:0] m_pc;
    bit          m_pv;
    logic [31:0] m_pt;
    int          m_pp;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk         (clk),
        .resetn      (resetn),
        .stallF      (stallF),
        .exc_valid   (exc_valid),
        .eret_valid  (eret_valid),
        .eret_pc     (eret_pc),
        .jumpD       (jumpD),
        .pc_jumpD    (pc_jumpD),
        .branch_takeD(branch_takeD),
        .pc_branchD  (pc_branchD),
        .inst_addr_ok(inst_addr_ok),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .pcF         (pcF),
        .pc_plus4F   (pc_plus4F),
        .adelF       (adelF)
    );

    function automatic logic [97:0] model_outs();
        logic req;
        req = (m_mode == 1) && (m_pc[1:0] == 2'b00);
        return {req, m_pc, m_pc, m_pc + 32'd4, m_pc[1:0] != 2'b00};
    endfunction

    function automatic logic [97:0] dut_outs();
        return {inst_req, inst_addr, pcF, pc_plus4F, adelF};
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_pc   = RESET_PC;
        m_pv   = 0;
        m_pt   = '0;
        m_pp   = 0;
    endtask

    // Drive one cycle of inputs, clock it, then advance the model.
    task automatic step(input bit st, input bit ex, input bit er, input logic [31:0] epc,
                        input bit j, input logic [31:0] jpc, input bit b,
                        input logic [31:0] bpc, input bit ok);
        int          p;
        logic [31:0] tgt;
        bit          req;
        stallF = st; exc_valid = ex; eret_valid = er; eret_pc = epc;
        jumpD = j; pc_jumpD = jpc; branch_takeD = b; pc_branchD = bpc; inst_addr_ok = ok;
        @(posedge clk);
        #1;
        req = (m_mode == 1) && (m_pc[1:0] == 2'b00);
        p   = er ? 3 : j ? 2 : b ? 1 : 0;
        tgt = er ? epc : j ? jpc : bpc;
        if (ex && m_mode != 0) begin
            m_pc = EXC_PC; m_pv = 0; m_mode = 1;
        end else if (req && ok) begin
            m_pc   = (p != 0) ? tgt : m_pv ? m_pt : m_pc + 32'd4;
            m_pv   = 0;
            m_mode = st ? 2 : 1;
        end else begin
            if (p != 0 && (!m_pv || p >= m_pp)) begin
                m_pv = 1; m_pt = tgt; m_pp = p;
            end
            if (m_mode == 0) m_mode = 1;
            else if (m_mode == 2 && !st) m_mode = 1;
        end
    endtask

    task automatic idle(input bit st, input bit ok);
        step(st, 0, 0, '0, 0, '0, 0, '0, ok);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle(0, 1);
        model_reset();
        checks++;
        if (dut_outs() !== model_outs())
            $display("FAIL reset_hold: got %h expected %h", dut_outs(), model_outs());
        else passed++;
        resetn = 1'b1;
        idle(0, 1);
        checks++;
        if (inst_req !== 1'b1 || inst_addr !== 32'hbfc0_0000)
            $display("FAIL boot_first: got req=%b addr=%h expected req=1 addr=bfc00000", inst_req, inst_addr);
        else passed++;
        idle(0, 1);
        checks++;
        if (inst_addr !== 32'hbfc0_0004)
            $display("FAIL seq_second: got %h expected bfc00004", inst_addr);
        else passed++;
        idle(0, 1);
        checks++;
        if (inst_addr !== 32'hbfc0_0008 || dut_outs() !== model_outs())
            $display("FAIL seq_third: got %h expected bfc00008 (%h)", inst_addr, model_outs());
        else passed++;
    endtask

    task automatic test_jump_wait();
        while (m_pc != 32'hbfc0_0010) idle(0, 1);
        step(0, 0, 0, '0, 1, 32'hbfc0_0100, 0, '0, 0);
        for (int i = 0; i < 2; i++) idle(0, 0);
        checks++;
        if (inst_addr !== 32'hbfc0_0010 || inst_req !== 1'b1)
            $display("FAIL jump_wait_hold: got req=%b addr=%h expected req=1 addr=bfc00010", inst_req, inst_addr);
        else passed++;
        idle(0, 1);
        checks++;
        if (inst_addr !== 32'hbfc0_0100 || dut_outs() !== model_outs())
            $display("FAIL jump_wait_target: got %h expected bfc00100", inst_addr);
        else passed++;
    endtask

    task automatic test_slot_priority();
        idle(1, 1);
        checks++;
        if (inst_req !== 1'b0 || dut_outs() !== model_outs())
            $display("FAIL stall_entry: got %h expected %h", dut_outs(), model_outs());
        else passed++;
        step(1, 0, 0, '0, 0, '0, 1, 32'h8000_0040, 0);
        step(1, 0, 0, '0, 1, 32'h8000_0080, 0, '0, 0);
        idle(0, 0);
        idle(0, 1);
        checks++;
        if (inst_addr !== 32'h8000_0080)
            $display("FAIL slot_jump_over_branch: got %h expected 80000080", inst_addr);
        else passed++;
        idle(1, 1);
        step(1, 0, 0, '0, 1, 32'h8000_0080, 0, '0, 0);
        step(1, 0, 0, '0, 0, '0, 1, 32'h8000_0040, 0);
        idle(0, 0);
        idle(0, 1);
        checks++;
        if (inst_addr !== 32'h8000_0080 || dut_outs() !== model_outs())
            $display("FAIL slot_branch_dropped: got %h expected 80000080", inst_addr);
        else passed++;
    endtask

    task automatic test_exception();
        step(0, 0, 0, '0, 0, '0, 1, 32'h8000_0200, 0);
        step(1, 1, 0, '0, 0, '0, 0, '0, 0);
        checks++;
        if (pcF !== EXC_PC || inst_req !== 1'b1)
            $display("FAIL exc_redirect: got req=%b pc=%h expected req=1 pc=bfc00380", inst_req, pcF);
        else passed++;
        idle(0, 1);
        checks++;
        if (pcF !== 32'hbfc0_0384 || dut_outs() !== model_outs())
            $display("FAIL exc_slot_cleared: got %h expected bfc00384", pcF);
        else passed++;
    endtask

    task automatic test_misaligned();
        step(0, 0, 0, '0, 1, 32'h8000_0002, 0, '0, 1);
        checks++;
        if (adelF !== 1'b1 || inst_req !== 1'b0)
            $display("FAIL adel_set: got adel=%b req=%b expected adel=1 req=0", adelF, inst_req);
        else passed++;
        for (int i = 0; i < 3; i++) idle(0, 1);
        checks++;
        if (pcF !== 32'h8000_0002 || inst_req !== 1'b0)
            $display("FAIL adel_hold: got pc=%h req=%b expected pc=80000002 req=0", pcF, inst_req);
        else passed++;
        step(0, 1, 0, '0, 0, '0, 0, '0, 1);
        checks++;
        if (pcF !== EXC_PC || adelF !== 1'b0 || dut_outs() !== model_outs())
            $display("FAIL adel_exc: got pc=%h adel=%b expected pc=bfc00380 adel=0", pcF, adelF);
        else passed++;
    endtask

    task automatic test_wrap_and_reset();
        step(0, 0, 0, '0, 1, 32'hffff_fffc, 0, '0, 1);
        checks++;
        if (pc_plus4F !== 32'h0000_0000)
            $display("FAIL plus4_wrap: got %h expected 00000000", pc_plus4F);
        else passed++;
        idle(0, 1);
        checks++;
        if (pcF !== 32'h0000_0000 || dut_outs() !== model_outs())
            $display("FAIL pc_wrap: got %h expected 00000000", pcF);
        else passed++;
        idle(0, 0);
        resetn = 1'b0;
        #2;
        model_reset();
        checks++;
        if (inst_req !== 1'b0 || pcF !== RESET_PC)
            $display("FAIL async_reset: got req=%b pc=%h expected req=0 pc=bfc00000", inst_req, pcF);
        else passed++;
        resetn = 1'b1;
        idle(0, 1);
        idle(0, 1);
        checks++;
        if (pcF !== 32'hbfc0_0004 || dut_outs() !== model_outs())
            $display("FAIL reset_restart: got %h expected bfc00004", pcF);
        else passed++;
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = $urandom & 32'hffff_fffc;
        if ($urandom_range(0, 15) == 0) t[1:0] = 2'($urandom_range(1, 3));
        return t;
    endfunction

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 7) == 0, rand_target(),
                 $urandom_range(0, 4) == 0, rand_target(),
                 $urandom_range(0, 3) == 0, rand_target(),
                 $urandom_range(0, 2) != 0);
            checks++;
            if (dut_outs() !== model_outs())
                $display("FAIL random_cycle_%0d: got %h expected %h", i, dut_outs(), model_outs());
            else passed++;
        end
    endtask

    initial begin
        resetn = 1'b0;
        stallF = 0; exc_valid = 0; eret_valid = 0; jumpD = 0; branch_takeD = 0;
        eret_pc = '0; pc_jumpD = '0; pc_branchD = '0; inst_addr_ok = 0;
        model_reset();
        test_reset();
        test_jump_wait();
        test_slot_priority();
        test_exception();
        test_misaligned();
        test_wrap_and_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
